// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//
// A two-entry pipeline register with a skid buffer. The main register feeds
// out_data directly. The skid register holds a second entry, so that in_ready
// can be computed from registered state alone and never combinationally from
// out_ready. Entries leave in the order they were accepted. An entry accepted
// into an empty stage appears on out_data one cycle later, and the stage
// sustains one transfer per cycle while out_ready stays high.
//
// Parameters
//   DATA_W      payload width in bits (1..256)
//   RESET_DATA  value loaded into main and skid on reset and on flush
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high; overrides everything else
//   en         in   stage enable; low freezes the stage and blocks both sides
//   flush      in   synchronous discard of all held entries (overrides en)
//   in_valid   in   upstream offers in_data
//   in_data    in   upstream payload
//   in_ready   out  stage can accept: en & not FULL
//   out_valid  out  out_data is valid: en & not EMPTY
//   out_data   out  downstream payload, straight from the main register
//   out_ready  in   downstream accepts
//   occupancy  out  held entries 0/1/2, independent of en
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  // The encoding equals the entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  logic w_in_fire;
  logic w_out_fire;

  // Both handshake outputs depend only on en and r_state, never on out_ready.
  assign in_ready   = en & (r_state != FULL);
  assign out_valid  = en & (r_state != EMPTY);
  assign out_data   = r_main;
  assign occupancy  = r_state;

  assign w_in_fire  = en & in_valid  & in_ready;
  assign w_out_fire = en & out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others (main <= skid below
  // relies on this).
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      // NOTE: the payload registers are reset as well as the state, because
      // out_data must show RESET_DATA after reset or flush rather than a stale
      // entry.
      r_state <= EMPTY;
      r_main  <= RESET_DATA;
      r_skid  <= RESET_DATA;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main  <= in_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            // The head leaves while the new entry replaces it. Skid stays unused.
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_skid  <= in_data;
            r_state <= FULL;
          end else if (w_out_fire) begin
            // main keeps its stale value. out_valid masks it.
            r_state <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the output side can move.
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
        default: begin
          r_state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Drives pipe_skid_reg with directed scenarios and then random traffic. The
// expected outputs come from a FIFO queue model of at most two entries:
// acceptance pushes to the queue, delivery pops from it, and reset or flush
// empties it. out_data is expected to be the queue head. When the queue is
// empty, out_data is expected to be the last value that left the stage, or
// RESET_DATA after a reset or flush.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int             DW   = 16;
  localparam logic [DW-1:0]  RDAT = 16'hDEAD;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    occupancy;

  pipe_skid_reg #(.DATA_W(DW), .RESET_DATA(RDAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_out;
  int            n_delivered;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Runs one clock cycle with the given inputs. Outputs are checked at the
  // falling edge. The model then advances across the rising edge.
  task automatic step(input logic r, input logic fl, input logic e,
                      input logic iv, input logic [DW-1:0] d, input logic ordy);
    logic          exp_ir, exp_ov, in_f, out_f;
    logic [DW-1:0] exp_data, popped;
    reset = r; flush = fl; en = e; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk);
    exp_ir   = e && (q.size() < 2);
    exp_ov   = e && (q.size() > 0);
    exp_data = (q.size() > 0) ? q[0] : last_out;
    check("in_ready",  {31'd0, in_ready},  {31'd0, exp_ir});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    check("occupancy", {30'd0, occupancy}, q.size());
    check("out_data",  {16'd0, out_data},  {16'd0, exp_data});
    // Flipping out_ready must leave in_ready unchanged.
    out_ready = ~ordy;
    #1;
    check("in_ready_vs_out_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    out_ready = ordy;
    #1;
    in_f  = exp_ir && iv;
    out_f = exp_ov && ordy;
    @(posedge clk);
    if (r || fl) begin
      q.delete();
      last_out = RDAT;
    end else begin
      if (out_f) begin
        popped = q.pop_front();
        n_delivered++;
        if (q.size() == 0) last_out = popped;
      end
      if (in_f) q.push_back(d);
    end
    #1;
  endtask

  initial begin
    n_delivered = 0;
    last_out    = RDAT;
    reset = 1'b1; flush = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Outputs after reset.
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, out_data},  {16'd0, RDAT});
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // Back-to-back pass-through with one cycle of latency.
    step(0, 0, 1, 1, 16'h00A1, 1);
    step(0, 0, 1, 1, 16'h00A2, 1);
    step(0, 0, 1, 1, 16'h00A3, 1);
    check("a3_out_data", {16'd0, out_data}, 32'h00A3);
    step(0, 0, 1, 0, 16'h0000, 1);

    // Fill the stage with the output stalled, then drain it in order.
    step(0, 0, 1, 1, 16'h0011, 0);
    step(0, 0, 1, 1, 16'h0022, 0);
    check("full_occupancy", {30'd0, occupancy}, 32'd2);
    check("full_out_data",  {16'd0, out_data},  32'h0011);
    step(0, 0, 1, 1, 16'h0033, 0);   // not accepted: the stage is full
    step(0, 0, 1, 1, 16'h0033, 1);   // 0x11 leaves
    step(0, 0, 1, 1, 16'h0033, 1);   // 0x22 leaves, 0x33 accepted
    step(0, 0, 1, 0, 16'h0000, 1);   // 0x33 leaves
    step(0, 0, 1, 0, 16'h0000, 1);

    // A flush from FULL empties the stage.
    step(0, 0, 1, 1, 16'h0055, 0);
    step(0, 0, 1, 1, 16'h0066, 0);
    step(0, 1, 1, 1, 16'h0099, 1);
    check("flush_out_data", {16'd0, out_data}, {16'd0, RDAT});
    step(0, 0, 1, 1, 16'h0044, 1);
    step(0, 0, 1, 0, 16'h0000, 1);

    // en low freezes the stage while both sides are requesting.
    step(0, 0, 1, 1, 16'h0077, 0);
    repeat (3) step(0, 0, 0, 1, 16'h0088, 1);
    check("en_hold_out_data", {16'd0, out_data}, 32'h0077);
    step(0, 0, 1, 0, 16'h0000, 1);
    step(0, 0, 1, 0, 16'h0000, 1);

    // Reset from FULL, together with flush, discards both entries.
    step(0, 0, 1, 1, 16'h0001, 0);
    step(0, 0, 1, 1, 16'h0002, 0);
    step(1, 1, 1, 1, 16'h0003, 1);
    check("rst_full_out_data", {16'd0, out_data}, {16'd0, RDAT});
    step(0, 0, 1, 0, 16'h0000, 1);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 255) == 0),
           ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 7) != 0),
           $urandom_range(0, 1),
           DW'($urandom),
           $urandom_range(0, 1));
    end
    step(0, 0, 1, 0, 16'h0000, 1);
    step(0, 0, 1, 0, 16'h0000, 1);
    step(0, 0, 1, 0, 16'h0000, 1);
    check("drained", {30'd0, occupancy}, 32'd0);
    if (n_delivered < 1000) check("random_throughput", n_delivered, 1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (legal range 1..256).
REQ-002 Parameter RESET_DATA, default 0, value loaded into both payload registers at reset and flush.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset; synchronous and active-high.
REQ-005 Port en  input  1  stage enable; low freezes the stage.
REQ-006 Port flush  input  1  synchronous discard of all held entries.
REQ-007 Port in_valid  input  1  upstream offers in_data.
REQ-008 Port in_data  input  DATA_W  upstream payload.
REQ-009 Port in_ready  output  1  stage can accept; driven from registered state only, no combinational path from out_ready.
REQ-010 Port out_valid  output  1  out_data is valid.
REQ-011 Port out_data  output  DATA_W  downstream payload, taken directly from the main register.
REQ-012 Port out_ready  input  1  downstream accepts.
REQ-013 Port occupancy  output  2  number of held entries: 0, 1 or 2.

Function
REQ-014 Storage shall be two DATA_W registers, main and skid, plus a state register with states EMPTY, ONE and FULL.
REQ-015 Define in_fire = en & in_valid & in_ready and out_fire = en & out_valid & out_ready.
REQ-016 in_ready shall equal en & (state != FULL).
REQ-017 out_valid shall equal en & (state != EMPTY).
REQ-018 occupancy shall encode EMPTY=0, ONE=1, FULL=2, independent of en.
REQ-019 EMPTY: on in_fire, main <= in_data and the next state is ONE; otherwise hold.
REQ-020 ONE with in_fire & out_fire: main <= in_data and the state stays ONE.
REQ-021 ONE with in_fire only: skid <= in_data and the next state is FULL.
REQ-022 ONE with out_fire only: the next state is EMPTY and main holds its stale value.
REQ-023 FULL: in_fire is impossible; on out_fire, main <= skid and the next state is ONE.
REQ-024 Ordering: entries shall leave in acceptance order with no loss and no duplication.
REQ-025 Latency: an entry accepted into EMPTY shall appear on out_data one cycle later; the maximum back-to-back throughput is one transfer per cycle.
REQ-026 en=0: no transfer on either side; state, main and skid shall hold; in_ready=0 and out_valid=0.
REQ-027 flush=1 (overrides en): the next state is EMPTY and main and skid are loaded with RESET_DATA.
REQ-028 flush=1: any concurrent in_fire or out_fire handshake is discarded and the upstream shall not retry it.
REQ-029 Registers outside the main-to-output and skid paths: none; the only other register is the 2-bit state.

Reset
REQ-030 reset=1 at a clock edge shall set the state to EMPTY and load main and skid with RESET_DATA.
REQ-031 reset shall take priority over flush, en and handshakes.
REQ-032 After reset: out_valid=0, occupancy=0, out_data=RESET_DATA, and in_ready=en.
REQ-033 Reset asserted mid-transfer shall discard all held entries; none shall reappear after reset is released.

Verification
REQ-034 Reset, then en=1, out_ready=1, in_valid=1 with data 0xA1,0xA2,0xA3 on consecutive cycles -> out_data 0xA1,0xA2,0xA3 one cycle later; occupancy stays 1; in_ready stays 1.
REQ-035 out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11; push 0x33 held (not accepted); out_ready=1 -> 0x11, 0x22, 0x33 in order.
REQ-036 FULL with 0x55/0x66, flush=1 for one cycle -> next cycle occupancy=0, out_valid=0, out_data=RESET_DATA; later pushes flow normally.
REQ-037 ONE holding 0x77, en=0 for 3 cycles with in_valid=1 and out_ready=1 -> no transfers, in_ready=0, out_valid=0; en=1 -> 0x77 delivered first.
REQ-038 FULL with 0x01/0x02, reset=1 with flush=1 -> EMPTY, out_data=RESET_DATA; 0x01 and 0x02 never appear.
REQ-039 Random in_valid and out_ready for 10k cycles against a scoreboard queue -> no loss, reorder or duplication; occupancy matches the queue depth; in_ready never depends combinationally on out_ready.
